// File: rtl/keypad_scan.sv
// Scans a 4x5 active-low key matrix, debounces whole-scan results and emits one pulse per new press.
// Latency: pulse one clock after the scan wrap where the debounce count first reaches DEBOUNCE_SCANS.
// Backpressure: none; o_key_valid is a one-cycle event that the consumer must take when it fires.
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [4:0] i_col,
  output logic [3:0] o_row,
  output logic       o_key_valid,
  output logic [4:0] o_key_value
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_MULTI = 5'd31;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  logic [4:0]    r_col_meta;
  logic [4:0]    r_col_sync;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_row;
  logic [19:0]   r_acc;
  logic [4:0]    r_prev;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_key_valid;
  logic [4:0]    r_key_value;

  logic          w_slot_last;
  logic          w_wrap;
  logic [4:0]    w_col_act;
  logic [19:0]   w_row_bits;
  logic [19:0]   w_acc_full;
  logic          w_any;
  logic          w_multi;
  logic [4:0]    w_idx;
  logic [4:0]    w_result;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_stable;
  logic          w_is_key;
  state_t        w_state_nxt;
  logic          w_pulse;

  assign w_slot_last = (r_slot == SW'(SCAN_DIV - 1));
  assign w_wrap      = w_slot_last && (r_row == 2'd3);
  assign w_col_act   = ~r_col_sync;
  assign o_row       = ~(4'b0001 << r_row);
  assign o_key_valid = r_key_valid;
  assign o_key_value = r_key_value;

  // Current row's sample merged in so the wrap sees all 20 positions in one cycle.
  always_comb begin
    w_row_bits = '0;
    case (r_row)
      2'd0:    w_row_bits[4:0]   = w_col_act;
      2'd1:    w_row_bits[9:5]   = w_col_act;
      2'd2:    w_row_bits[14:10] = w_col_act;
      default: w_row_bits[19:15] = w_col_act;
    endcase
    w_acc_full = r_acc | w_row_bits;
  end

  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < 20; i++) begin
      if (w_acc_full[i]) begin
        w_multi = w_multi | w_any;
        w_any   = 1'b1;
        w_idx   = 5'(i);
      end
    end
    if (!w_any)       w_result = KEY_NONE;
    else if (w_multi) w_result = KEY_MULTI;
    else              w_result = w_idx + 5'd1;
  end

  always_comb begin
    w_cnt_nxt = CW'(1);
    if (w_result == r_prev) begin
      w_cnt_nxt = (r_cnt == CW'(DEBOUNCE_SCANS)) ? r_cnt : r_cnt + CW'(1);
    end
    w_stable = w_wrap && (w_cnt_nxt == CW'(DEBOUNCE_SCANS));
    w_is_key = (w_result != KEY_NONE) && (w_result != KEY_MULTI);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    if (w_stable) begin
      case (r_state)
        RELEASED: begin
          if (w_is_key) begin
            w_pulse     = 1'b1;
            w_state_nxt = PRESSED;
          end
        end
        default: begin
          if (w_result == KEY_NONE) w_state_nxt = RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= RELEASED;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_col_meta  <= 5'h1F;
      r_col_sync  <= 5'h1F;
      r_slot      <= '0;
      r_row       <= 2'd0;
      r_acc       <= '0;
      r_prev      <= KEY_NONE;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_key_value <= KEY_NONE;
    end else begin
      r_col_meta  <= i_col;
      r_col_sync  <= r_col_meta;
      r_key_valid <= w_pulse;
      if (w_pulse) r_key_value <= w_result;
      if (w_slot_last) begin
        r_slot <= '0;
        r_row  <= r_row + 2'd1;
        r_acc  <= w_wrap ? 20'd0 : w_acc_full;
      end else begin
        r_slot <= r_slot + SW'(1);
      end
      if (w_wrap) begin
        r_cnt  <= w_cnt_nxt;
        r_prev <= w_result;
      end
    end
  end

endmodule
